// File: rtl/edu_token_scan_pkg.sv
// Shared constants and FSM encoding for the EDU token-setup scanner.
package edu_token_scan_pkg;

  localparam int EDU_NUM_AQROW_DEF = 8;
  localparam int EDU_NUM_ROW_DEF   = 4;

  typedef enum logic {
    EDU_TS_IDLE = 1'b0,
    EDU_TS_EMIT = 1'b1
  } edu_ts_state_e;

endpackage

// File: rtl/edu_token_mask_gen.sv
// Combinational token/flag mask generator for one ancilla-qubit row.
// Shifts are done one bit wider than the mask so col = NUM_AQROW-1 cannot overflow.
module edu_token_mask_gen
  import edu_token_scan_pkg::*;
#(
  parameter int NUM_AQROW  = EDU_NUM_AQROW_DEF,
  parameter int COLADDR_BW = $clog2(NUM_AQROW + 1)
) (
  input  logic                  exist,
  input  logic [COLADDR_BW-1:0] col,
  input  logic                  mode,
  output logic [NUM_AQROW-1:0]  token_set,
  output logic [NUM_AQROW-1:0]  flag_set
);

  localparam int                    WIDE_W    = NUM_AQROW + 1;
  localparam logic [WIDE_W-1:0]     ONE_W     = WIDE_W'(1);
  localparam logic [COLADDR_BW-1:0] COL_LIMIT = COLADDR_BW'(NUM_AQROW);

  logic              in_range_s;
  logic [WIDE_W-1:0] one_hot_s;
  logic [WIDE_W-1:0] below_s;
  logic [WIDE_W-1:0] upto_s;

  // Build one-hot, strictly-below and up-to-and-including masks, then select.
  always_comb begin
    in_range_s = exist && (col < COL_LIMIT);
    one_hot_s  = ONE_W << col;
    below_s    = one_hot_s - ONE_W;
    upto_s     = (one_hot_s << 1) - ONE_W;
    token_set  = '0;
    flag_set   = '0;
    if (in_range_s) begin
      token_set = one_hot_s[NUM_AQROW-1:0];
      if (mode) begin
        flag_set = ~below_s[NUM_AQROW-1:0];
      end else begin
        flag_set = upto_s[NUM_AQROW-1:0];
      end
    end else begin
      token_set = '0;
      flag_set  = '0;
    end
  end

endmodule

// File: rtl/edu_token_scan.sv
// Accepts one token request and sweeps its masks over rows row0..NUM_ROW-1,
// one backpressured beat per row, with registered outputs.
module edu_token_scan
  import edu_token_scan_pkg::*;
#(
  parameter int NUM_AQROW  = EDU_NUM_AQROW_DEF,
  parameter int NUM_ROW    = EDU_NUM_ROW_DEF,
  parameter int COLADDR_BW = $clog2(NUM_AQROW + 1),
  parameter int ROWADDR_BW = $clog2(NUM_ROW + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_exist,
  input  logic [COLADDR_BW-1:0] req_col,
  input  logic                  req_mode,
  input  logic [ROWADDR_BW-1:0] req_row0,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ROWADDR_BW-1:0] out_row,
  output logic [NUM_AQROW-1:0]  token_set,
  output logic [NUM_AQROW-1:0]  flag_set,
  output logic                  out_last,
  output logic                  req_err
);

  localparam logic [ROWADDR_BW-1:0] ROW_LIMIT = ROWADDR_BW'(NUM_ROW);
  localparam logic [ROWADDR_BW-1:0] ROW_LAST  = ROWADDR_BW'(NUM_ROW - 1);
  localparam logic [ROWADDR_BW-1:0] ROW_ONE   = ROWADDR_BW'(1);
  localparam logic [COLADDR_BW-1:0] COL_LIMIT = COLADDR_BW'(NUM_AQROW);

  edu_ts_state_e           state_q, state_d;
  logic [ROWADDR_BW-1:0]   row_q, row_d;
  logic [NUM_AQROW-1:0]    token_q, token_d;
  logic [NUM_AQROW-1:0]    flag_q, flag_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    err_q, err_d;
  logic [NUM_AQROW-1:0]    gen_token_s;
  logic [NUM_AQROW-1:0]    gen_flag_s;
  logic [ROWADDR_BW-1:0]   row_inc_s;

  edu_token_mask_gen #(
    .NUM_AQROW  (NUM_AQROW),
    .COLADDR_BW (COLADDR_BW)
  ) u_mask_gen (
    .exist     (req_exist),
    .col       (req_col),
    .mode      (req_mode),
    .token_set (gen_token_s),
    .flag_set  (gen_flag_s)
  );

  // Next-state and next-output logic for the request/sweep FSM.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    token_d   = token_q;
    flag_d    = flag_q;
    valid_d   = valid_q;
    last_d    = last_q;
    err_d     = 1'b0;
    row_inc_s = row_q + ROW_ONE;
    case (state_q)
      EDU_TS_IDLE: begin
        if (req_valid) begin
          if (req_row0 >= ROW_LIMIT) begin
            err_d = 1'b1;
          end else begin
            state_d = EDU_TS_EMIT;
            row_d   = req_row0;
            token_d = gen_token_s;
            flag_d  = gen_flag_s;
            valid_d = 1'b1;
            last_d  = (req_row0 == ROW_LAST);
            err_d   = (req_col >= COL_LIMIT);
          end
        end else begin
          state_d = EDU_TS_IDLE;
        end
      end
      EDU_TS_EMIT: begin
        if (out_ready) begin
          if (row_q == ROW_LAST) begin
            state_d = EDU_TS_IDLE;
            row_d   = '0;
            token_d = '0;
            flag_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            row_d  = row_inc_s;
            last_d = (row_inc_s == ROW_LAST);
          end
        end else begin
          state_d = EDU_TS_EMIT;
        end
      end
      default: begin
        state_d = EDU_TS_IDLE;
        row_d   = '0;
        token_d = '0;
        flag_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EDU_TS_IDLE;
      row_q   <= '0;
      token_q <= '0;
      flag_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      token_q <= token_d;
      flag_q  <= flag_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == EDU_TS_IDLE) && !rst;
  assign out_valid = valid_q;
  assign out_row   = row_q;
  assign token_set = token_q;
  assign flag_set  = flag_q;
  assign out_last  = last_q;
  assign req_err   = err_q;

endmodule

// File: tb/tb_edu_token_scan.sv
// Directed bench for edu_token_scan: a per-beat queue model checked every cycle,
// plus literal expectations and a second NUM_AQROW=6 instance for the out-of-range column case.
module tb_edu_token_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_exist, req_mode, out_ready;
  logic [3:0] req_col;
  logic [2:0] req_row0;
  logic       req_ready, out_valid, out_last, req_err;
  logic [2:0] out_row;
  logic [7:0] token_set, flag_set;

  logic       b_req_valid, b_req_ready, b_out_valid, b_out_last, b_req_err;
  logic [2:0] b_req_col, b_out_row;
  logic [5:0] b_token_set, b_flag_set;

  int checks   = 0;
  int failures = 0;
  int beats_seen = 0;

  typedef struct {
    int         row;
    logic [7:0] tok;
    logic [7:0] flg;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  logic  exp_err = 1'b0;

  edu_token_scan #(.NUM_AQROW(8), .NUM_ROW(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_exist(req_exist), .req_col(req_col), .req_mode(req_mode), .req_row0(req_row0),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .token_set(token_set), .flag_set(flag_set), .out_last(out_last), .req_err(req_err)
  );

  edu_token_scan #(.NUM_AQROW(6), .NUM_ROW(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_exist(1'b1), .req_col(b_req_col), .req_mode(1'b0), .req_row0(3'd0),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_row(b_out_row),
    .token_set(b_token_set), .flag_set(b_flag_set), .out_last(b_out_last), .req_err(b_req_err)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Token mask: only bit col, and only for an existing in-range token.
  function automatic logic [7:0] m_tok(input logic e, input int c);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) m[i] = e && (c < 8) && (i == c);
    return m;
  endfunction

  // Flag mask: bits 0..col (mode 0) or col..7 (mode 1).
  function automatic logic [7:0] m_flg(input logic e, input int c, input logic md);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) m[i] = e && (c < 8) && (md ? (i >= c) : (i <= c));
    return m;
  endfunction

  // Model update for the posedge just passed (inputs are still the sampled ones), then compare.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_err = 1'b0;
    end else begin
      logic was_idle;
      was_idle = (exp_q.size() == 0);
      exp_err = 1'b0;
      if (!was_idle && out_ready) begin
        void'(exp_q.pop_front());
        beats_seen++;
      end
      if (was_idle && req_valid) begin
        if (int'(req_row0) >= 4) begin
          exp_err = 1'b1;
        end else begin
          exp_err = (int'(req_col) >= 8);
          for (int r = int'(req_row0); r < 4; r++) begin
            beat_t b;
            b.row  = r;
            b.tok  = m_tok(req_exist, int'(req_col));
            b.flg  = m_flg(req_exist, int'(req_col), req_mode);
            b.last = (r == 3);
            exp_q.push_back(b);
          end
        end
      end
    end
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("req_err", 32'(req_err), 32'(exp_err));
    chk("req_ready", 32'(req_ready), 32'((exp_q.size() == 0) && !rst));
    if (exp_q.size() != 0) begin
      chk("out_row", 32'(out_row), 32'(exp_q[0].row));
      chk("token_set", 32'(token_set), 32'(exp_q[0].tok));
      chk("flag_set", 32'(flag_set), 32'(exp_q[0].flg));
      chk("out_last", 32'(out_last), 32'(exp_q[0].last));
    end
  end

  task automatic do_req(input logic e, input logic [3:0] c, input logic m, input logic [2:0] r0);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_exist = e;
    req_col   = c;
    req_mode  = m;
    req_row0  = r0;
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("idle_wait", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int b0;
    rst = 1'b1; req_valid = 1'b0; req_exist = 1'b0; req_col = 4'd0;
    req_mode = 1'b0; req_row0 = 3'd0; out_ready = 1'b1;
    b_req_valid = 1'b0; b_req_col = 3'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_token", 32'(token_set), 32'd0);
    chk("rst_flag", 32'(flag_set), 32'd0);
    chk("rst_ready_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Scenario 1: col=3 mode 0 full sweep
    b0 = beats_seen;
    do_req(1'b1, 4'd3, 1'b0, 3'd0);
    chk("s1_token", 32'(token_set), 32'h08);
    chk("s1_flag", 32'(flag_set), 32'h0F);
    chk("s1_row", 32'(out_row), 32'd0);
    wait_idle();
    chk("s1_beats", 32'(beats_seen - b0), 32'd4);

    // Scenario 2: col=5 mode 1 from row 2
    b0 = beats_seen;
    do_req(1'b1, 4'd5, 1'b1, 3'd2);
    chk("s2_token", 32'(token_set), 32'h20);
    chk("s2_flag", 32'(flag_set), 32'hE0);
    chk("s2_row", 32'(out_row), 32'd2);
    wait_idle();
    chk("s2_beats", 32'(beats_seen - b0), 32'd2);

    // Scenario 3: stall three cycles on row 1
    b0 = beats_seen;
    do_req(1'b1, 4'd3, 1'b0, 3'd0);
    @(negedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("s3_stall_row", 32'(out_row), 32'd1);
      chk("s3_stall_flag", 32'(flag_set), 32'h0F);
    end
    out_ready = 1'b1;
    wait_idle();
    chk("s3_beats", 32'(beats_seen - b0), 32'd4);

    // Scenario 4: non-existent token, zero masks and no error
    b0 = beats_seen;
    do_req(1'b0, 4'd7, 1'b0, 3'd1);
    chk("s4_err", 32'(req_err), 32'd0);
    chk("s4_token", 32'(token_set), 32'd0);
    wait_idle();
    chk("s4_beats", 32'(beats_seen - b0), 32'd3);

    // Boundary masks: mode 0 col 7 and mode 1 col 0 give all ones
    do_req(1'b1, 4'd7, 1'b0, 3'd3);
    chk("b_m0_flag", 32'(flag_set), 32'hFF);
    chk("b_m0_last", 32'(out_last), 32'd1);
    wait_idle();
    do_req(1'b1, 4'd0, 1'b1, 3'd3);
    chk("b_m1_flag", 32'(flag_set), 32'hFF);
    chk("b_m1_token", 32'(token_set), 32'h01);
    wait_idle();
    do_req(1'b1, 4'd8, 1'b0, 3'd2);
    chk("col8_err", 32'(req_err), 32'd1);
    chk("col8_flag", 32'(flag_set), 32'd0);
    wait_idle();

    // Scenario 5: row0 out of range
    do_req(1'b1, 4'd3, 1'b0, 3'd4);
    chk("s5_err", 32'(req_err), 32'd1);
    chk("s5_valid", 32'(out_valid), 32'd0);
    chk("s5_ready", 32'(req_ready), 32'd1);

    // Scenario 6: reset on row 2, then a fresh sweep
    do_req(1'b1, 4'd3, 1'b0, 3'd0);
    repeat (2) begin @(negedge clk); #1; end
    chk("s6_row_before", 32'(out_row), 32'd2);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("s6_valid", 32'(out_valid), 32'd0);
    chk("s6_flag", 32'(flag_set), 32'd0);
    chk("s6_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    #1;
    chk("s6_ready", 32'(req_ready), 32'd1);
    b0 = beats_seen;
    do_req(1'b1, 4'd3, 1'b0, 3'd0);
    chk("s6b_token", 32'(token_set), 32'h08);
    wait_idle();
    chk("s6b_beats", 32'(beats_seen - b0), 32'd4);

    // Reset together with a request: request dropped
    rst = 1'b1; req_valid = 1'b1; req_row0 = 3'd0;
    @(negedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    chk("rst_req_valid", 32'(out_valid), 32'd0);

    // NUM_AQROW=6 instance: col 7 is out of range
    b_req_valid = 1'b1; b_req_col = 3'd7;
    @(negedge clk); #1;
    b_req_valid = 1'b0;
    chk("b6_err", 32'(b_req_err), 32'd1);
    chk("b6_valid", 32'(b_out_valid), 32'd1);
    chk("b6_token", 32'(b_token_set), 32'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      chk("b6_err_low", 32'(b_req_err), 32'd0);
      chk("b6_row", 32'(b_out_row), 32'(k));
      chk("b6_flag", 32'(b_flag_set), 32'd0);
      chk("b6_last", 32'(b_out_last), 32'(k == 3));
    end
    @(negedge clk); #1;
    chk("b6_done_valid", 32'(b_out_valid), 32'd0);
    chk("b6_done_ready", 32'(b_req_ready), 32'd1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
